// File: rtl/instr_fetch_unit.sv
// Purpose : fetch stage between a combinational program ROM and execute; owns the
//           fetch PC, captures {pc, inst} into a 2-entry prefetch buffer and
//           presents the head to execute with a valid/ready handshake.
// Latency : reset release -> head valid after one edge (zero with FETCH_BYPASS_EN);
//           redirect -> target valid two edges later (one with FETCH_BYPASS_EN).
// Backpressure: out_ready low lets the buffer fill to 2, then the fetch PC holds.
//
// Optional feature macro: FETCH_BYPASS_EN
//   Defined  : with an empty buffer and no redirect, the ROM output is presented
//              combinationally and, if accepted, consumed without being buffered.
//   Undefined: every output is derived from registered state only.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   rom_addr         ROM address, always the fetch PC register
//   rom_data         combinational ROM data for rom_addr
//   redirect_valid   taken branch/jump: flush buffer, restart fetch at redirect_pc
//   redirect_pc      redirect target
//   out_valid        head of buffer holds an instruction
//   out_inst/out_pc  head instruction and its PC
//   out_ready        execute accepts the head this cycle
module instr_fetch_unit #(
  parameter int                 ADDR_W   = 8,
  parameter int                 INST_W   = 6,
  parameter logic [ADDR_W-1:0]  RESET_PC = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              out_ready
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        count_q, count_d;
  entry_t            slot_q [2];
  entry_t            slot_d [2];

  entry_t            head;
  logic              buf_valid;
  logic              buf_pop;
  logic              byp_act;
  logic              byp_take;
  logic              push;

  assign head      = slot_q[rd_ptr_q];
  assign buf_valid = (count_q != 2'd0);
  assign rom_addr  = fetch_pc_q;

`ifdef FETCH_BYPASS_EN
  // An empty buffer forwards the ROM word straight to execute unless a redirect
  // is flushing the stream this cycle.
  assign byp_act   = (count_q == 2'd0) && !redirect_valid;
  assign out_valid = buf_valid || byp_act;
  assign out_inst  = byp_act ? rom_data   : head.inst;
  assign out_pc    = byp_act ? fetch_pc_q : head.pc;
`else
  assign byp_act   = 1'b0;
  assign out_valid = buf_valid;
  assign out_inst  = head.inst;
  assign out_pc    = head.pc;
`endif

  // Buffer pop only happens from a non-empty buffer; a bypassed word is consumed
  // directly and must not also be written.
  assign buf_pop  = buf_valid && out_ready;
  assign byp_take = byp_act && out_ready;
  assign push     = !byp_take && ((count_q != 2'd2) || buf_pop);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    slot_d[0]  = slot_q[0];
    slot_d[1]  = slot_q[1];

    if (redirect_valid) begin
      // Redirect wins over any push/pop: the presented head is dropped, not consumed.
      fetch_pc_d = redirect_pc;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
      count_d    = 2'd0;
    end else begin
      if (push) begin
        slot_d[wr_ptr_q] = '{pc: fetch_pc_q, inst: rom_data};
        wr_ptr_d         = ~wr_ptr_q;
      end
      if (push || byp_take) begin
        // Wraps modulo 2^ADDR_W.
        fetch_pc_d = fetch_pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
      if (buf_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, buf_pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      slot_q[0]  <= '0;
      slot_q[1]  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      slot_q[0]  <= slot_d[0];
      slot_q[1]  <= slot_d[1];
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam int AW = 8;
  localparam int IW = 6;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] rom_addr;
  logic [IW-1:0] rom_data;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          out_valid;
  logic [IW-1:0] out_inst;
  logic [AW-1:0] out_pc;
  logic          out_ready;

  logic [IW-1:0] rom [0:255];
  logic [IW-1:0] seq [4];

  int total = 0;
  int bad   = 0;

  assign rom_data = rom[rom_addr];

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(AW), .INST_W(IW), .RESET_PC(8'h00)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_ready      (out_ready)
  );

  // Hold reset, check the reset state of every output.
  task automatic test_reset();
    rst_n          = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    for (int i = 0; i < 256; i++) rom[i] = IW'($urandom);
    rom[8'h00] = 6'h12; rom[8'h01] = 6'h28; rom[8'h02] = 6'h3B; rom[8'h03] = 6'h12;
    rom[8'h1A] = 6'h01; rom[8'h1B] = 6'h17;
    rom[8'hFE] = 6'h3F; rom[8'hFF] = 6'h3F;
    seq[0] = 6'h12; seq[1] = 6'h28; seq[2] = 6'h3B; seq[3] = 6'h12;
    repeat (3) @(negedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++; if (out_pc !== 8'h00) begin bad++; $display("FAIL reset_pc got=%h want=00", out_pc); end
    total++; if (out_inst !== 6'h00) begin bad++; $display("FAIL reset_inst got=%h want=00", out_inst); end
    total++; if (rom_addr !== 8'h00) begin bad++; $display("FAIL reset_rom_addr got=%h want=00", rom_addr); end
  endtask

  // Release reset with out_ready=1; expect (00,12),(01,28),(02,3B),(03,12) back to back.
  task automatic test_sequential();
    int idx = 0;
    int lat = BYP ? 0 : 1;
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0;
    for (int c = 0; c < 8 && idx < 4; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      total++;
      if (out_valid !== (c >= lat)) begin
        bad++; $display("FAIL seq_valid cyc=%0d got=%b want=%b", c, out_valid, (c >= lat));
      end
      if (out_valid === 1'b1) begin
        total++;
        if (out_pc !== AW'(idx) || out_inst !== seq[idx]) begin
          bad++; $display("FAIL seq_data got=(%h,%h) want=(%h,%h)", out_pc, out_inst, AW'(idx), seq[idx]);
        end
        idx++;
      end
    end
    total++; if (idx != 4) begin bad++; $display("FAIL seq_count got=%0d want=4", idx); end
  endtask

  // Release reset with out_ready=0: buffer fills, fetch PC holds at 02, head stays 00.
  task automatic test_stall();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || out_pc !== 8'h00 || rom_addr !== 8'h02) begin
        bad++; $display("FAIL stall_hold got=(v%b pc%h addr%h) want=(v1 pc00 addr02)", out_valid, out_pc, rom_addr);
      end
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      total++;
      if (out_valid !== 1'b1 || out_pc !== AW'(k) || out_inst !== seq[k]) begin
        bad++; $display("FAIL stall_drain got=(v%b %h,%h) want=(v1 %h,%h)", out_valid, out_pc, out_inst, AW'(k), seq[k]);
      end
    end
  endtask

  // Redirect while the head is 03 with out_ready=1; expect n instructions from tgt.
  task automatic run_redirect(input logic [AW-1:0] head_pc, input logic [AW-1:0] tgt, input int n);
    int idx = 0;
    int lat = BYP ? 0 : 1;
    logic [AW-1:0] p;
    @(negedge clk); #1;
    total++;
    if (out_valid !== 1'b1 || out_pc !== head_pc) begin
      bad++; $display("FAIL redir_head got=(v%b %h) want=(v1 %h)", out_valid, out_pc, head_pc);
    end
    redirect_valid = 1'b1; redirect_pc = tgt; out_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int c = 0; c < 8 && idx < n; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      total++;
      if (out_valid !== (c >= lat)) begin
        bad++; $display("FAIL redir_valid cyc=%0d got=%b want=%b", c, out_valid, (c >= lat));
      end
      if (out_valid === 1'b1) begin
        p = tgt + AW'(idx);
        total++;
        if (out_pc !== p || out_inst !== rom[p]) begin
          bad++; $display("FAIL redir_data got=(%h,%h) want=(%h,%h)", out_pc, out_inst, p, rom[p]);
        end
        idx++;
      end
    end
    total++; if (idx != n) begin bad++; $display("FAIL redir_count got=%0d want=%0d", idx, n); end
  endtask

  task automatic test_redirect();
    run_redirect(8'h03, 8'h1A, 2);
  endtask

  // Head is now 1C; jump to FE and follow the PC across the FF->00 wrap.
  task automatic test_wrap();
    run_redirect(8'h1C, 8'hFE, 3);
  endtask

  // Fill the buffer, drop rst_n between edges, expect immediate flush, then restart.
  task automatic test_async_reset();
    @(negedge clk); out_ready = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || rom_addr !== 8'h00 || out_pc !== 8'h00 || out_inst !== 6'h00) begin
      bad++; $display("FAIL async_reset got=(v%b addr%h pc%h inst%h) want=(v0 addr00 pc00 inst00)",
                      out_valid, rom_addr, out_pc, out_inst);
    end
    test_sequential();
  endtask

  // Random ready/redirect traffic against a stream model: the head must always be
  // the next PC in program order since the last redirect, with inst = rom[pc].
  task automatic test_random();
    logic [AW-1:0] exp_pc;
    bit            prev_redir;
    bit            exp_v;
    @(negedge clk);
    for (int i = 0; i < 256; i++) rom[i] = IW'($urandom);
    redirect_valid = 1'b1; redirect_pc = AW'($urandom); out_ready = 1'b0;
    exp_pc = redirect_pc; prev_redir = 1'b1;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = AW'($urandom);
      out_ready      = ($urandom_range(0, 3) != 0);
      #1;
      exp_v = BYP ? 1'b1 : !prev_redir;
      if (!(BYP && redirect_valid)) begin
        total++;
        if (out_valid !== exp_v) begin
          bad++; $display("FAIL rand_valid cyc=%0d got=%b want=%b", c, out_valid, exp_v);
        end
      end
      if (out_valid === 1'b1) begin
        total++;
        if (out_pc !== exp_pc || out_inst !== rom[exp_pc]) begin
          bad++; $display("FAIL rand_data cyc=%0d got=(%h,%h) want=(%h,%h)", c, out_pc, out_inst, exp_pc, rom[exp_pc]);
        end
      end
      if (redirect_valid) begin
        exp_pc = redirect_pc; prev_redir = 1'b1;
      end else begin
        if (out_valid === 1'b1 && out_ready) exp_pc = exp_pc + 8'h01;
        prev_redir = 1'b0;
      end
    end
    @(negedge clk); redirect_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_wrap();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
